// File: rtl/cv_serial_sched.sv
// ---------------------------------------------------------------------------
// cv_serial_sched
//   Arbitrates two requesters, each presenting one Excess-3 digit, and drives
//   an external bit-serial Excess-3 -> BCD converter (LSB first, Mealy output,
//   active-low reset). A conversion takes 6 cycles from the accept edge:
//   CLR (converter reset), 4 x BIT (one bit per cycle), DONE (result pulse).
//   Arbitration between requesters is round-robin.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req[1:0]   in   per-requester request, held until acknowledged
//   din0, din1 in   Excess-3 digits of requester 0 / 1
//   ack[1:0]   out  one-cycle acceptance pulse (one-hot or zero)
//   dout[3:0]  out  BCD result, holds its value outside DONE
//   dout_valid out  one-cycle result strobe
//   dout_id    out  requester index of the result
//   err        out  accepted code was out of range
//   cv_x       out  serial bit to the converter
//   cv_rst_n   out  converter reset, active-low
//   cv_z       in   converter Mealy output for the current cv_x
//
// Configuration
//   CV_RANGE_CHECK_EN  when defined, an accepted code outside 3..12 skips the
//                      converter and goes straight to DONE with err=1 and
//                      dout=4'hF. When undefined, err is constant 0.
// ---------------------------------------------------------------------------
module cv_serial_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] din0,
  input  logic [3:0] din1,
  output logic [1:0] ack,
  output logic [3:0] dout,
  output logic       dout_valid,
  output logic       dout_id,
  output logic       err,
  output logic       cv_x,
  output logic       cv_rst_n,
  input  logic       cv_z
);

  typedef enum logic [1:0] {IDLE, CLR, BIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] k;
  logic       ptr;
  logic [3:0] lat_din;
  logic       lat_id;
  logic [2:0] result;
  logic       accept;
  logic       win;
  logic [3:0] din_sel;
  logic       bad_sel;
  logic       bad_q;

  // A lone requester always wins; with both requesting, the pointer decides.
  always_comb begin
    win = ptr;
    if (req == 2'b01) win = 1'b0;
    if (req == 2'b10) win = 1'b1;
  end

  assign din_sel = win ? din1 : din0;
  assign accept  = ((state == IDLE) || (state == DONE)) && (req != 2'b00);

`ifdef CV_RANGE_CHECK_EN
  assign bad_sel = (din_sel < 4'd3) || (din_sel > 4'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bad_q <= 1'b0;
    else if (accept) bad_q <= bad_sel;
  end
`else
  assign bad_sel = 1'b0;
  assign bad_q   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_sel ? DONE : CLR;
      CLR:     state_nxt = BIT;
      BIT:     if (k == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = accept ? (bad_sel ? DONE : CLR) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: bit counter, round-robin pointer, result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= 2'd0;
      ptr     <= 1'b0;
      dout    <= 4'd0;
      dout_id <= 1'b0;
    end else begin
      if (state == CLR) k <= 2'd0;
      else if (state == BIT) k <= k + 2'd1;
      if (accept) begin
        ptr <= ~win;
        if (bad_sel) begin
          dout    <= 4'hF;
          dout_id <= win;
        end
      end
      // Last bit arrives on the edge that enters DONE; fold it straight in.
      if ((state == BIT) && (k == 2'd3)) begin
        dout    <= {cv_z, result};
        dout_id <= lat_id;
      end
    end
  end

  // Data registers: latched operand and partial result
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_din <= din_sel;
      lat_id  <= win;
    end
    if ((state == BIT) && (k != 2'd3)) result[k] <= cv_z;
  end

  // Output logic
  always_comb begin
    ack        = 2'b00;
    cv_x       = 1'b0;
    cv_rst_n   = 1'b0;
    dout_valid = 1'b0;
    err        = 1'b0;
    case (state)
      CLR: ack = lat_id ? 2'b10 : 2'b01;
      BIT: begin
        cv_rst_n = 1'b1;
        cv_x     = lat_din[k];
      end
      DONE: begin
        dout_valid = 1'b1;
        err        = bad_q;
        // A rejected code never visits CLR, so its acknowledge lands here.
        if (bad_q) ack = lat_id ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule
